cache_arbiter: RTL

Arbitrates the single burst-memory port (64-bit beats, 4 beats per 256-bit line) between the instruction cache and the data cache in the pipelined RV32I core. The block grants one cache line transaction at a time, serializes and deserializes the line, and returns a one-cycle response to the granted cache. It sits between the cache pair and the `bmem_*` interface exported by `mp4`.

---
 rtl/cache_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Grants one I/D cache line at a time to the 4-beat burst port. Busy 6+ cycles per line (grant, 4 beats, resp).
// Backpressure: requests are held and wait in IDLE; bmem_resp stalls each beat; spurious resps are ignored.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  bmem_address,
    output logic         bmem_read,
    output logic         bmem_write,
    input  logic [63:0]  bmem_rdata,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_resp
);

    typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    state_t       state, state_nxt;
    logic [1:0]   cnt, cnt_nxt;
    logic [255:0] line, line_nxt;
    logic [26:0]  line_addr, line_addr_nxt;
    logic         last_grant, last_grant_nxt;
    logic         granted, granted_nxt;

    logic         i_req, d_req, pick_d;
    logic         unused_addr_bits;

    assign i_req  = i_read;
    assign d_req  = d_read | d_write;
    // On a tie the requester that was not served last wins.
    assign pick_d = d_req & (~i_req | (last_grant == SEL_I));
    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            line       <= '0;
            line_addr  <= '0;
            last_grant <= SEL_D;
            granted    <= SEL_I;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            line       <= line_nxt;
            line_addr  <= line_addr_nxt;
            last_grant <= last_grant_nxt;
            granted    <= granted_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        line_nxt       = line;
        line_addr_nxt  = line_addr;
        last_grant_nxt = last_grant;
        granted_nxt    = granted;
        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    granted_nxt    = pick_d;
                    last_grant_nxt = pick_d;
                    cnt_nxt        = 2'd0;
                    if (pick_d) begin
                        line_addr_nxt = d_addr[31:5];
                        if (d_write) begin
                            line_nxt  = d_wdata;
                            state_nxt = D_WRITE;
                        end else begin
                            state_nxt = D_READ;
                        end
                    end else begin
                        line_addr_nxt = i_addr[31:5];
                        state_nxt     = I_READ;
                    end
                end
            end
            I_READ, D_READ: begin
                if (bmem_resp) begin
                    line_nxt[{cnt, 6'b0} +: 64] = bmem_rdata;
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = DONE;
                end
            end
            D_WRITE: begin
                if (bmem_resp) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bmem_address = {line_addr, 5'b0};
    assign bmem_read    = (state == I_READ) || (state == D_READ);
    assign bmem_write   = (state == D_WRITE);
    assign bmem_wdata   = (state == D_WRITE) ? line[{cnt, 6'b0} +: 64] : 64'd0;
    assign i_resp       = (state == DONE) && (granted == SEL_I);
    assign d_resp       = (state == DONE) && (granted == SEL_D);
    assign i_rdata      = line;
    assign d_rdata      = line;

endmodule
